// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: shadow EX/MEM/WB destination tracking, stall/bubble/flush
// generation, redirect sequencing and stall/redirect perf counters.
module id_hazard_ctrl #(
  parameter int FWD_EN       = 1,
  parameter int WB_BYPASS    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_idValid,
  input  logic [4:0]       i_rdReg1,
  input  logic [4:0]       i_rdReg2,
  input  logic             i_idMemRead,
  input  logic             i_idRegWrite,
  input  logic [4:0]       i_idWrReg,
  input  logic             i_exRedirect,
  output logic             o_stallPC,
  output logic             o_stallIFID,
  output logic             o_bubbleIDEX,
  output logic             o_flushIFID,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stallCnt,
  output logic [CNT_W-1:0] o_flushCnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_STALL = 2'b01,
    S_FLUSH = 2'b10
  } state_t;

  state_t          r_state;
  logic [FC_W-1:0] r_fcnt;

  // Shadow pipe; mem-read only matters while the instr sits in EX
  logic       r_exV, r_exRw, r_exMr;
  logic [4:0] r_exRd;
  logic       r_memV, r_memRw;
  logic [4:0] r_memRd;
  logic       r_wbV, r_wbRw;
  logic [4:0] r_wbRd;

  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  logic w_matchEx, w_matchMem, w_matchWb;
  logic w_hazard, w_redirect, w_flushing, w_stall, w_bubble;

  function automatic logic f_match(input logic v, input logic rw,
                                   input logic [4:0] rd, input logic [4:0] r);
    return v & rw & (rd != 5'd0) & (r != 5'd0) & (rd == r);
  endfunction

  assign w_matchEx  = f_match(r_exV,  r_exRw,  r_exRd,  i_rdReg1) |
                      f_match(r_exV,  r_exRw,  r_exRd,  i_rdReg2);
  assign w_matchMem = f_match(r_memV, r_memRw, r_memRd, i_rdReg1) |
                      f_match(r_memV, r_memRw, r_memRd, i_rdReg2);
  assign w_matchWb  = f_match(r_wbV,  r_wbRw,  r_wbRd,  i_rdReg1) |
                      f_match(r_wbV,  r_wbRw,  r_wbRd,  i_rdReg2);

  always_comb begin
    w_hazard = 1'b0;
    if (i_idValid) begin
      if (FWD_EN != 0)
        w_hazard = w_matchEx & r_exMr;
      else
        w_hazard = w_matchEx | w_matchMem | (w_matchWb & (WB_BYPASS == 0));
    end
  end

  assign w_redirect = i_exRedirect;
  assign w_flushing = w_redirect | (r_state == S_FLUSH);
  assign w_stall    = ~w_flushing & w_hazard;
  assign w_bubble   = w_flushing | w_stall;

  assign o_stallPC    = w_stall;
  assign o_stallIFID  = w_stall;
  assign o_bubbleIDEX = w_bubble;
  assign o_flushIFID  = w_flushing;
  assign o_state      = r_state;
  assign o_stallCnt   = r_stallCnt;
  assign o_flushCnt   = r_flushCnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_RUN;
      r_fcnt     <= '0;
      r_exV      <= 1'b0;
      r_exRw     <= 1'b0;
      r_exMr     <= 1'b0;
      r_exRd     <= 5'd0;
      r_memV     <= 1'b0;
      r_memRw    <= 1'b0;
      r_memRd    <= 5'd0;
      r_wbV      <= 1'b0;
      r_wbRw     <= 1'b0;
      r_wbRd     <= 5'd0;
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      r_wbV   <= r_memV;
      r_wbRw  <= r_memRw;
      r_wbRd  <= r_memRd;
      r_memV  <= r_exV;
      r_memRw <= r_exRw;
      r_memRd <= r_exRd;
      if (i_idValid && !w_bubble) begin
        r_exV  <= 1'b1;
        r_exRw <= i_idRegWrite;
        r_exMr <= i_idMemRead;
        r_exRd <= i_idWrReg;
      end else begin
        r_exV  <= 1'b0;
        r_exRw <= 1'b0;
        r_exMr <= 1'b0;
        r_exRd <= 5'd0;
      end

      if (w_stall)
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (w_redirect)
        r_flushCnt <= r_flushCnt + CNT_W'(1);

      // The redirect cycle is itself the first flush cycle, so FLUSH state
      // only covers the remaining FLUSH_CYCLES-1 cycles (r_fcnt counts them).
      if (w_redirect) begin
        r_fcnt  <= FC_LOAD;
        r_state <= (FC_LOAD != '0) ? S_FLUSH : S_RUN;
      end else begin
        case (r_state)
          S_RUN:   if (w_hazard) r_state <= S_STALL;
          S_STALL: if (!w_hazard) r_state <= S_RUN;
          S_FLUSH: begin
            if (r_fcnt <= FC_W'(1)) begin
              r_fcnt  <= '0;
              r_state <= S_RUN;
            end else begin
              r_fcnt <= r_fcnt - FC_W'(1);
            end
          end
          default: r_state <= S_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: four parameterisations share one stimulus stream;
// a vector table drives the default build, hand sequences cover multi-cycle corners.
module tb_id_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] rs1, rs2, wr;
  logic       mr, rw, redir;

  // index 0: defaults, 1: FWD_EN=0/WB_BYPASS=1, 2: FWD_EN=0/WB_BYPASS=0, 3: FLUSH_CYCLES=3
  logic        stall_pc  [4];
  logic        stall_ifid[4];
  logic        bubble    [4];
  logic        flush     [4];
  logic [1:0]  state     [4];
  logic [15:0] scnt      [4];
  logic [15:0] fcnt      [4];

  int n_tests = 0;
  int n_fail  = 0;

  id_hazard_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_idValid(id_valid), .i_rdReg1(rs1), .i_rdReg2(rs2),
    .i_idMemRead(mr), .i_idRegWrite(rw), .i_idWrReg(wr), .i_exRedirect(redir),
    .o_stallPC(stall_pc[0]), .o_stallIFID(stall_ifid[0]), .o_bubbleIDEX(bubble[0]),
    .o_flushIFID(flush[0]), .o_state(state[0]), .o_stallCnt(scnt[0]), .o_flushCnt(fcnt[0]));

  id_hazard_ctrl #(.FWD_EN(0), .WB_BYPASS(1)) u_nf1 (
    .i_clk(clk), .i_rst(rst), .i_idValid(id_valid), .i_rdReg1(rs1), .i_rdReg2(rs2),
    .i_idMemRead(mr), .i_idRegWrite(rw), .i_idWrReg(wr), .i_exRedirect(redir),
    .o_stallPC(stall_pc[1]), .o_stallIFID(stall_ifid[1]), .o_bubbleIDEX(bubble[1]),
    .o_flushIFID(flush[1]), .o_state(state[1]), .o_stallCnt(scnt[1]), .o_flushCnt(fcnt[1]));

  id_hazard_ctrl #(.FWD_EN(0), .WB_BYPASS(0)) u_nf0 (
    .i_clk(clk), .i_rst(rst), .i_idValid(id_valid), .i_rdReg1(rs1), .i_rdReg2(rs2),
    .i_idMemRead(mr), .i_idRegWrite(rw), .i_idWrReg(wr), .i_exRedirect(redir),
    .o_stallPC(stall_pc[2]), .o_stallIFID(stall_ifid[2]), .o_bubbleIDEX(bubble[2]),
    .o_flushIFID(flush[2]), .o_state(state[2]), .o_stallCnt(scnt[2]), .o_flushCnt(fcnt[2]));

  id_hazard_ctrl #(.FLUSH_CYCLES(3)) u_fl3 (
    .i_clk(clk), .i_rst(rst), .i_idValid(id_valid), .i_rdReg1(rs1), .i_rdReg2(rs2),
    .i_idMemRead(mr), .i_idRegWrite(rw), .i_idWrReg(wr), .i_exRedirect(redir),
    .o_stallPC(stall_pc[3]), .o_stallIFID(stall_ifid[3]), .o_bubbleIDEX(bubble[3]),
    .o_flushIFID(flush[3]), .o_state(state[3]), .o_stallCnt(scnt[3]), .o_flushCnt(fcnt[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] r1, r2;
    logic       m, w;
    logic [4:0] d;
    logic       rd;
    logic       e_stall, e_bubble, e_flush;
    logic [1:0] e_state;
    int         e_scnt, e_fcnt;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic vld, input int r1, input int r2, input logic m,
                              input logic w, input int d, input logic rd, input logic es,
                              input logic eb, input logic ef, input int est, input int esc,
                              input int efc);
    vec_t v;
    v.vld = vld; v.r1 = 5'(r1); v.r2 = 5'(r2); v.m = m; v.w = w; v.d = 5'(d); v.rd = rd;
    v.e_stall = es; v.e_bubble = eb; v.e_flush = ef; v.e_state = 2'(est);
    v.e_scnt = esc; v.e_fcnt = efc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int a, input int b, input logic m,
                       input logic w, input int d, input logic r);
    id_valid = v; rs1 = 5'(a); rs2 = 5'(b); mr = m; rw = w; wr = 5'(d); redir = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  logic exp_f3[9]   = '{1, 1, 1, 0, 1, 1, 1, 1, 0};
  int   exp_st3[9]  = '{0, 2, 2, 0, 0, 2, 2, 2, 0};
  logic exp_f1[9]   = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
  logic redir_seq[9] = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
  logic exp_nf1[6]  = '{0, 1, 1, 0, 0, 0};
  logic exp_nf0[6]  = '{0, 1, 1, 1, 0, 0};

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    //        vld r1 r2 m w d  rd  stl bub fl st sc fc
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // idle after reset
    vecs[1]  = mk(1, 2, 0, 1, 1, 5, 0,  0, 0, 0, 0, 0, 0);  // lw x5
    vecs[2]  = mk(1, 5, 7, 0, 1, 6, 0,  1, 1, 0, 0, 0, 0);  // add x6,x5,x7 load-use
    vecs[3]  = mk(1, 5, 7, 0, 1, 6, 0,  0, 0, 0, 1, 1, 0);  // held, resolved
    vecs[4]  = mk(1, 1, 2, 0, 1, 5, 0,  0, 0, 0, 0, 1, 0);  // add x5
    vecs[5]  = mk(1, 5, 5, 0, 1, 8, 0,  0, 0, 0, 0, 1, 0);  // sub x8,x5,x5 forwarded
    vecs[6]  = mk(1, 2, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0);  // lw x0
    vecs[7]  = mk(1, 0, 0, 0, 1, 9, 0,  0, 0, 0, 0, 1, 0);  // use x0
    vecs[8]  = mk(1, 2, 0, 1, 1, 10, 0, 0, 0, 0, 0, 1, 0);  // lw x10
    vecs[9]  = mk(1, 10, 10, 0, 1, 11, 1, 0, 1, 1, 0, 1, 0); // load-use + redirect
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 1, 1);  // bare redirect
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 2);
    vecs[13] = mk(1, 2, 0, 1, 1, 5, 0,  0, 0, 0, 0, 1, 2);  // lw x5
    vecs[14] = mk(1, 1, 5, 0, 1, 7, 0,  1, 1, 0, 0, 1, 2);  // hazard via rs2
    vecs[15] = mk(1, 1, 5, 0, 1, 7, 0,  0, 0, 0, 1, 2, 2);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 2);
    vecs[17] = mk(1, 2, 0, 1, 1, 5, 0,  0, 0, 0, 0, 2, 2);  // lw x5
    vecs[18] = mk(0, 5, 0, 0, 1, 6, 0,  0, 0, 0, 0, 2, 2);  // invalid ID never hazards

    next_cycle();
    do_reset();

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].vld, int'(vecs[i].r1), int'(vecs[i].r2), vecs[i].m, vecs[i].w,
            int'(vecs[i].d), vecs[i].rd);
      @(negedge clk);
      chk("stallPC",   i, int'(stall_pc[0]),   int'(vecs[i].e_stall));
      chk("stallIFID", i, int'(stall_ifid[0]), int'(vecs[i].e_stall));
      chk("bubble",    i, int'(bubble[0]),     int'(vecs[i].e_bubble));
      chk("flush",     i, int'(flush[0]),      int'(vecs[i].e_flush));
      chk("state",     i, int'(state[0]),      int'(vecs[i].e_state));
      chk("stallCnt",  i, int'(scnt[0]),       vecs[i].e_scnt);
      chk("flushCnt",  i, int'(fcnt[0]),       vecs[i].e_fcnt);
      next_cycle();
    end

    // No forwarding: ALU result dependency stalls 2 (bypass) / 3 (no bypass) cycles
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(1, 1, 2, 0, 1, 5, 0);
      else        drive(1, 5, 7, 0, 1, 6, 0);
      @(negedge clk);
      chk("nf1_stall", c, int'(stall_pc[1]), int'(exp_nf1[c]));
      chk("nf0_stall", c, int'(stall_pc[2]), int'(exp_nf0[c]));
      chk("fwd_stall", c, int'(stall_pc[0]), 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("nf1_stallCnt", 0, int'(scnt[1]), 2);
    chk("nf0_stallCnt", 0, int'(scnt[2]), 3);
    chk("fwd_stallCnt", 0, int'(scnt[0]), 0);
    next_cycle();

    // FLUSH_CYCLES=3 redirect, then a second redirect restarting the flush window
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(0, 0, 0, 0, 0, 0, redir_seq[c]);
      @(negedge clk);
      chk("fl3_flush", c, int'(flush[3]), int'(exp_f3[c]));
      chk("fl3_state", c, int'(state[3]), exp_st3[c]);
      chk("fl1_flush", c, int'(flush[0]), int'(exp_f1[c]));
      next_cycle();
    end
    chk("fl3_flushCnt", 0, int'(fcnt[3]), 3);

    // Redirect coinciding with a load-use stall
    do_reset();
    drive(1, 2, 0, 1, 1, 5, 0);
    next_cycle();
    drive(1, 5, 7, 0, 1, 6, 1);
    @(negedge clk);
    chk("ru_stallPC", 0, int'(stall_pc[3]), 0);
    chk("ru_flush",   0, int'(flush[3]),    1);
    chk("ru_bubble",  0, int'(bubble[3]),   1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ru_state",    1, int'(state[3]), 2);
    chk("ru_flushCnt", 1, int'(fcnt[3]),  1);
    chk("ru_stallCnt", 1, int'(scnt[3]),  0);
    next_cycle();

    // Reset asserted while in STALL (no-forwarding, no-bypass build)
    do_reset();
    drive(1, 1, 2, 0, 1, 5, 0);
    next_cycle();
    drive(1, 5, 7, 0, 1, 6, 0);
    next_cycle();
    @(negedge clk);
    chk("rs_pre_state", 0, int'(state[2]),    1);
    chk("rs_pre_stall", 0, int'(stall_pc[2]), 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_stallPC",  1, int'(stall_pc[2]), 0);
    chk("rs_bubble",   1, int'(bubble[2]),   0);
    chk("rs_flush",    1, int'(flush[2]),    0);
    chk("rs_state",    1, int'(state[2]),    0);
    chk("rs_stallCnt", 1, int'(scnt[2]),     0);
    chk("rs_flushCnt", 1, int'(fcnt[2]),     0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
